// File: rtl/pc_unit.sv
// Program counter with hold/inc/jump/relative-branch and an optional call/return stack.
// Define PC_STACK_EN to build the return stack; otherwise CALL acts as JMP and RET as HOLD.
module pc_unit #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         pc,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty,
  output logic                     err
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OpHold = 3'b000,
    OpInc  = 3'b001,
    OpJmp  = 3'b010,
    OpBra  = 3'b011,
    OpCall = 3'b100,
    OpRet  = 3'b101,
    OpRsv6 = 3'b110,
    OpRsv7 = 3'b111
  } op_e;

  localparam logic [WIDTH-1:0] PcOne = WIDTH'(1);

  op_e              op_sel;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_bra;

  assign op_sel = op_e'(op);
  assign pc_inc = pc_q + PcOne;
  // Plain modular add implements a signed offset in two's complement.
  assign pc_bra = pc_q + din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

`ifdef PC_STACK_EN

  localparam logic [PtrW:0] DepthOne = (PtrW + 1)'(1);
  localparam logic [PtrW:0] DepthMax = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [PtrW:0]    depth_q, depth_d;
  logic             err_q, err_d;
  logic             push;
  logic [PtrW-1:0]  push_idx;
  logic [PtrW-1:0]  top_idx;
  logic             full_w;
  logic             empty_w;

  assign full_w   = (depth_q == DepthMax);
  assign empty_w  = (depth_q == '0);
  assign push_idx = depth_q[PtrW-1:0];
  assign top_idx  = PtrW'(depth_q - DepthOne);

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    err_d   = err_q;
    push    = 1'b0;
    if (en) begin
      case (op_sel)
        OpInc: pc_d = pc_inc;
        OpJmp: pc_d = din;
        OpBra: pc_d = pc_bra;
        OpCall: begin
          if (full_w) begin
            err_d = 1'b1;
          end else begin
            push    = 1'b1;
            pc_d    = din;
            depth_d = depth_q + DepthOne;
          end
        end
        OpRet: begin
          if (empty_w) begin
            err_d = 1'b1;
          end else begin
            pc_d    = stack_q[top_idx];
            depth_d = depth_q - DepthOne;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Entries are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign depth = depth_q;
  assign full  = full_w;
  assign empty = empty_w;
  assign err   = err_q;

`else

  always_comb begin
    pc_d = pc_q;
    if (en) begin
      case (op_sel)
        OpInc:         pc_d = pc_inc;
        OpJmp, OpCall: pc_d = din;
        OpBra:         pc_d = pc_bra;
        default: ;
      endcase
    end
  end

  assign depth = '0;
  assign full  = 1'b0;
  assign empty = 1'b1;
  assign err   = 1'b0;

`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit; expectations follow PC_STACK_EN the same way the design does.
module tb_pc_unit;

  localparam int unsigned      WIDTH     = 8;
  localparam int unsigned      DEPTH     = 4;
  localparam logic [WIDTH-1:0] RESET_VEC = 8'h10;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_BRA  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_R6   = 3'b110;
  localparam logic [2:0] OP_R7   = 3'b111;

  logic             clk;
  logic             rst;
  logic             en;
  logic [2:0]       op;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] pc;
  logic [2:0]       depth;
  logic             full;
  logic             empty;
  logic             err;

  int n_vec;
  int n_bad;

  pc_unit #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_VEC(RESET_VEC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .op   (op),
    .din  (din),
    .pc   (pc),
    .depth(depth),
    .full (full),
    .empty(empty),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one op across a rising edge, then settle 1 ns past it for sampling.
  task automatic step(input logic e, input logic [2:0] o, input logic [WIDTH-1:0] d);
    en  = e;
    op  = o;
    din = d;
    @(posedge clk);
    #1;
    en  = 1'b0;
    op  = OP_HOLD;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    en    = 1'b0;
    op    = OP_HOLD;
    din   = '0;
    #12;
    check("rst_pc", 32'(pc), 32'h10);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, OP_INC, 8'h00);
    check("inc1", 32'(pc), 32'h11);
    step(1'b1, OP_INC, 8'h00);
    check("inc2", 32'(pc), 32'h12);
    step(1'b1, OP_INC, 8'h00);
    check("inc3", 32'(pc), 32'h13);

    // Asynchronous reset, sampled well away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pc", 32'(pc), 32'h10);
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, OP_JMP, 8'hFF);
    check("jmp_ff", 32'(pc), 32'hFF);
    step(1'b1, OP_INC, 8'h00);
    check("inc_wrap", 32'(pc), 32'h00);
    step(1'b1, OP_JMP, 8'h05);
    step(1'b1, OP_BRA, 8'hFD);
    check("bra_neg", 32'(pc), 32'h02);
    step(1'b1, OP_JMP, 8'hFE);
    step(1'b1, OP_BRA, 8'h04);
    check("bra_wrap", 32'(pc), 32'h02);
    step(1'b1, OP_HOLD, 8'h77);
    check("hold", 32'(pc), 32'h02);
    step(1'b0, OP_JMP, 8'h33);
    check("en_off_pc", 32'(pc), 32'h02);
    step(1'b1, OP_R7, 8'h44);
    check("rsv7_pc", 32'(pc), 32'h02);
    check("rsv7_err", 32'(err), 32'd0);
    step(1'b1, OP_R6, 8'h45);
    check("rsv6_pc", 32'(pc), 32'h02);

`ifdef PC_STACK_EN
    step(1'b1, OP_JMP, 8'h20);
    step(1'b1, OP_CALL, 8'h40);
    check("call1_pc", 32'(pc), 32'h40);
    check("call1_depth", 32'(depth), 32'd1);
    step(1'b1, OP_CALL, 8'h60);
    check("call2_pc", 32'(pc), 32'h60);
    check("call2_depth", 32'(depth), 32'd2);
    step(1'b1, OP_RET, 8'h00);
    check("ret1_pc", 32'(pc), 32'h41);
    check("ret1_depth", 32'(depth), 32'd1);
    step(1'b1, OP_RET, 8'h00);
    check("ret2_pc", 32'(pc), 32'h21);
    check("ret2_empty", 32'(empty), 32'd1);
    check("ret2_err", 32'(err), 32'd0);

    step(1'b1, OP_RET, 8'h00);
    check("under_pc", 32'(pc), 32'h21);
    check("under_err", 32'(err), 32'd1);
    step(1'b1, OP_JMP, 8'h50);
    check("err_sticky", 32'(err), 32'd1);
    do_reset();
    check("err_cleared", 32'(err), 32'd0);

    step(1'b1, OP_JMP, 8'h00);
    step(1'b1, OP_CALL, 8'h10);
    step(1'b1, OP_CALL, 8'h20);
    step(1'b1, OP_CALL, 8'h30);
    check("call3_full", 32'(full), 32'd0);
    step(1'b1, OP_CALL, 8'h40);
    check("call4_full", 32'(full), 32'd1);
    check("call4_depth", 32'(depth), 32'd4);
    check("call4_pc", 32'(pc), 32'h40);
    step(1'b1, OP_CALL, 8'h50);
    check("over_pc", 32'(pc), 32'h40);
    check("over_depth", 32'(depth), 32'd4);
    check("over_err", 32'(err), 32'd1);
    step(1'b1, OP_RET, 8'h00);
    check("over_ret_pc", 32'(pc), 32'h31);
    check("over_ret_depth", 32'(depth), 32'd3);
    check("over_ret_err", 32'(err), 32'd1);
    step(1'b1, OP_CALL, 8'h70);
    step(1'b1, OP_RET, 8'h00);
    check("b2b_ret_pc", 32'(pc), 32'h32);
    step(1'b1, OP_RET, 8'h00);
    check("deep_ret_pc", 32'(pc), 32'h21);
    step(1'b0, OP_RET, 8'h00);
    check("en_off_ret_pc", 32'(pc), 32'h21);
    check("en_off_ret_depth", 32'(depth), 32'd2);
`else
    step(1'b1, OP_JMP, 8'h20);
    step(1'b1, OP_CALL, 8'h40);
    check("nostk_call_pc", 32'(pc), 32'h40);
    check("nostk_call_depth", 32'(depth), 32'd0);
    check("nostk_call_empty", 32'(empty), 32'd1);
    step(1'b1, OP_RET, 8'h00);
    check("nostk_ret_pc", 32'(pc), 32'h40);
    check("nostk_ret_err", 32'(err), 32'd0);
    step(1'b1, OP_RET, 8'h00);
    check("nostk_ret2_err", 32'(err), 32'd0);
    check("nostk_full", 32'(full), 32'd0);
    step(1'b1, OP_INC, 8'h00);
    check("nostk_inc_pc", 32'(pc), 32'h41);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
